ifetch: RTL and testbench
=========================

# ifetch

Instruction-fetch stage of the single-issue RV32I core. It owns the program counter, drives the byte address into the combinational instruction memory `imem` and takes back the 32-bit little-endian word. It registers `{pc, instruction}` into the IF/ID pipeline register and hands it to decode over a valid/ready handshake. It also applies branch/jump redirects from execute and flags fetch-address faults.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `IMEM_BYTES`, default 1024: size of the instruction memory in bytes. A fetch address is in range iff `addr <= IMEM_BYTES-4`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `imem_addr`  out  32  byte address to `imem`; always equal to the PC register, with no combinational path from inputs.
- `imem_rdata`  in  32  instruction word from `imem`, valid in the same cycle as `imem_addr`.
- `redirect_valid`  in  1  execute requests a control-flow change.
- `redirect_pc`  in  32  target address, sampled when `redirect_valid` is 1.
- `id_valid`  out  1  IF/ID register holds an instruction.
- `id_ready`  in  1  decode accepts the IF/ID contents this cycle.
- `id_instr`  out  32  fetched instruction.
- `id_pc`  out  32  address of `id_instr`.
- `id_pc_plus4`  out  32  `id_pc + 4`, modulo 2^32.
- `id_fault`  out  1  the fetch was misaligned (`pc[1:0] != 0`) or out of range.

## Operation
- State machine with two states:
  - RUN: fetching.
  - HALT: a fault has been issued; no further fetches.
- Condition definitions:
  - `can_load = !id_valid || id_ready`
  - `fire = can_load && state==RUN && !redirect_valid`
- Priority per cycle, highest first:
  1. **Reset** (`rst_n==0`):
     - `pc=RESET_PC`, `state=RUN`.
     - `id_valid=0`, `id_instr=32'h0000_0013` (NOP), `id_pc=0`, `id_pc_plus4=4`, `id_fault=0`.
  2. **Redirect** (`redirect_valid==1`):
     - `pc<=redirect_pc`, `id_valid<=0` (flush), `id_fault<=0`, `state<=RUN`.
     - Takes effect regardless of `id_ready` or state. The instruction currently at `imem_addr` is discarded.
  3. **Fire, good address**:
     - `id_valid<=1`, `id_instr<=imem_rdata`, `id_pc<=pc`, `id_pc_plus4<=pc+4`, `id_fault<=0`.
     - `pc<=pc+4`.
  4. **Fire, faulting address**:
     - `id_valid<=1`, `id_instr<=32'h0000_0013`, `id_pc<=pc`, `id_pc_plus4<=pc+4`, `id_fault<=1`.
     - `pc` unchanged, `state<=HALT`.
  5. **Stall** (`id_valid && !id_ready`): every register holds its value.
  6. **HALT with `id_valid && id_ready`**: `id_valid<=0`. The PC holds until a redirect.
- `imem_rdata` is never sampled while faulting; out-of-range bytes are undefined and must not reach decode.
- PC arithmetic is 32-bit and wraps. With the range check active, a wrap can only appear in `id_pc_plus4`.
- The IF/ID outputs are stable whenever `id_valid && !id_ready`.

## Timing
- Reset release: `imem_addr=RESET_PC` in the first cycle; `id_valid=1` with that instruction at the next edge.
- Throughput is one instruction per cycle while `id_ready=1`.
- Redirect asserted in cycle N:
  - `imem_addr=redirect_pc` in cycle N+1.
  - The target instruction is presented on `id_*` in cycle N+2.
  - Redirect penalty: one bubble cycle on `id_valid` after the flush.
- Redirect and stall in the same cycle: the redirect wins and the stalled entry is dropped.
- Back-to-back redirects in N and N+1: only the N+1 target is fetched; the N target never reaches decode.
- Fault: `id_fault` is visible one cycle after `imem_addr` holds the bad address. No later `id_valid` appears until a redirect.

## Test plan
- **Reset and sequential fetch**
  - Stimulus: memory preloaded with 0x00f00093 at 0, 0x01600113 at 4, 0x002081b3 at 8; `id_ready=1`.
  - Required: after reset release, consecutive cycles show `id_pc`=0/4/8 with those words, `id_pc_plus4`=4/8/12, `id_fault=0`.
- **Stall hold**
  - Stimulus: `id_ready=0` for 3 cycles while `id_pc=4`.
  - Required: `id_instr` stays 0x01600113 and `imem_addr` stays 8; releasing `id_ready` resumes at `id_pc=8` with no loss or duplication.
- **Redirect**
  - Stimulus: `redirect_valid=1`, `redirect_pc=0x48` in cycle N, during a stall.
  - Required: `id_valid=0` at N+1, `imem_addr=0x48` at N+1, `id_pc=0x48` with `id_valid=1` at N+2.
- **Misaligned target**
  - Stimulus: redirect to 0x4A.
  - Required: `id_fault=1`, `id_instr=0x00000013`, `id_pc=0x4A`; no further valid entries; a redirect to 0 then restarts a normal fetch.
- **Out of range**
  - Stimulus: redirect to 0x3FC, then continue.
  - Required: 0x3FC is fetched normally; 0x400 faults with `id_fault=1` and HALT.
- **Reset mid-stall**
  - Stimulus: assert `rst_n=0` while `id_valid=1` and `id_ready=0`.
  - Required: next edge gives `id_valid=0`, `imem_addr=RESET_PC`, `id_fault=0`.

Source files
------------

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, reads the combinational imem and
// loads {pc, instruction} into the IF/ID register behind a valid/ready
// handshake. Redirects from execute flush the register. A misaligned or
// out-of-range fetch issues a NOP flagged as a fault, then halts fetching
// until the next redirect.
//
// state | meaning
// ------+---------------------------------------------
// RUN   | fetching one word per accepted slot
// HALT  | fault issued, no further fetch until redirect
module ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        id_fault
);

  localparam logic       RUN       = 1'b0;
  localparam logic       HALT      = 1'b1;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LAST_ADDR = 32'(IMEM_BYTES - 4);

  logic        state;
  logic [31:0] pc;
  logic        can_load;
  logic        fire;
  logic        addr_fault;

  assign imem_addr  = pc;
  assign can_load   = !id_valid || id_ready;
  assign fire       = can_load && (state == RUN) && !redirect_valid;
  assign addr_fault = (pc[1:0] != 2'b00) || (pc > LAST_ADDR);

  // PC, fetch state and IF/ID register update in priority order:
  // reset, redirect, fetch (good or faulting), stall hold, halt drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= RUN;
      id_valid    <= 1'b0;
      id_instr    <= NOP;
      id_pc       <= 32'h0000_0000;
      id_pc_plus4 <= 32'h0000_0004;
      id_fault    <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      id_valid <= 1'b0;
      id_fault <= 1'b0;
      state    <= RUN;
    end else if (fire) begin
      id_valid    <= 1'b1;
      id_pc       <= pc;
      id_pc_plus4 <= pc + 32'd4;
      if (addr_fault) begin
        // Out-of-range data is undefined, so a NOP stands in for it.
        id_instr <= NOP;
        id_fault <= 1'b1;
        state    <= HALT;
      end else begin
        id_instr <= imem_rdata;
        id_fault <= 1'b0;
        pc       <= pc + 32'd4;
      end
    end else if ((state == HALT) && id_valid && id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic        id_fault;

  logic [31:0] mem [256];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] pc;
    bit          halted;
    bit          v;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [31:0] ip4;
    bit          f;
  } mst_t;

  mst_t m;

  ifetch #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_fault       (id_fault)
  );

  always #5 clk = ~clk;

  // Unmapped or misaligned reads return garbage that must never reach decode.
  assign imem_rdata = (imem_addr[1:0] == 2'b00 && imem_addr <= 32'd1020)
                      ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the architectural behaviour: what decode should see next.
  function automatic mst_t mnext(mst_t s, bit rstn, bit rv, logic [31:0] rpc, bit rdy);
    mst_t n = s;
    bit   faulty;
    if (!rstn) begin
      n.pc = 32'h0; n.halted = 0; n.v = 0;
      n.instr = NOP; n.ipc = 32'h0; n.ip4 = 32'd4; n.f = 0;
    end else if (rv) begin
      n.pc = rpc; n.v = 0; n.f = 0; n.halted = 0;
    end else if (s.v && !rdy) begin
      n = s;
    end else if (s.halted) begin
      n.v = 0;
    end else begin
      faulty = (s.pc % 4 != 0) || (s.pc > 32'd1020);
      n.v   = 1;
      n.ipc = s.pc;
      n.ip4 = s.pc + 32'd4;
      n.f   = faulty;
      if (faulty) begin
        n.instr  = NOP;
        n.halted = 1;
      end else begin
        n.instr = mem[s.pc / 4];
        n.pc    = s.pc + 32'd4;
      end
    end
    return n;
  endfunction

  task automatic step();
    mst_t nx;
    nx = mnext(m, rst_n, redirect_valid, redirect_pc, id_ready);
    @(posedge clk);
    #1;
    m = nx;
    chk("imem_addr", imem_addr, m.pc);
    chk("id_valid", {31'b0, id_valid}, {31'b0, m.v});
    chk("id_fault", {31'b0, id_fault}, {31'b0, m.f});
    chk("id_instr", id_instr, m.instr);
    chk("id_pc", id_pc, m.ipc);
    chk("id_pc_plus4", id_pc_plus4, m.ip4);
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc    = a;
    step();
    redirect_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 9))
      0:       return {$urandom_range(0, 255), 2'b00} | 32'h0 + 32'd0 + {22'b0, 10'($urandom_range(1, 3))} & 32'h3;
      1:       return 32'd1020;
      2:       return 32'd1008;
      3:       return 32'd1024;
      4:       return 32'hFFFF_FFFC;
      5:       return $urandom;
      default: return 32'($urandom_range(0, 255)) * 32'd4;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h00f0_0093;
    mem[1] = 32'h0160_0113;
    mem[2] = 32'h0020_81b3;
    m = '{pc: 32'h0, halted: 0, v: 0, instr: NOP, ipc: 32'h0, ip4: 32'd4, f: 0};

    rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    step();
    step();
    chk("rst_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_instr", id_instr, NOP);
    chk("rst_addr", imem_addr, 32'h0);

    // Sequential fetch from reset
    rst_n = 1'b1;
    step();
    chk("seq0_pc", id_pc, 32'h0);
    chk("seq0_instr", id_instr, 32'h00f0_0093);
    step();
    chk("seq1_instr", id_instr, 32'h0160_0113);
    chk("seq1_p4", id_pc_plus4, 32'd8);

    // Stall while id_pc=4
    id_ready = 1'b0;
    repeat (3) begin
      step();
      chk("stall_instr", id_instr, 32'h0160_0113);
      chk("stall_addr", imem_addr, 32'd8);
    end
    id_ready = 1'b1;
    step();
    chk("resume_pc", id_pc, 32'd8);
    chk("resume_instr", id_instr, 32'h0020_81b3);

    // Redirect during a stall
    id_ready = 1'b0;
    redirect_to(32'h48);
    chk("redir_bubble", {31'b0, id_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h48);
    id_ready = 1'b1;
    step();
    chk("redir_pc", id_pc, 32'h48);
    chk("redir_valid", {31'b0, id_valid}, 32'd1);

    // Misaligned target
    redirect_to(32'h4A);
    step();
    chk("mis_fault", {31'b0, id_fault}, 32'd1);
    chk("mis_instr", id_instr, NOP);
    chk("mis_pc", id_pc, 32'h4A);
    repeat (3) begin
      step();
      chk("mis_halt", {31'b0, id_valid}, 32'd0);
    end
    redirect_to(32'h0);
    step();
    chk("restart_instr", id_instr, 32'h00f0_0093);

    // Top-of-memory boundary
    redirect_to(32'h3FC);
    step();
    chk("last_fault", {31'b0, id_fault}, 32'd0);
    chk("last_instr", id_instr, mem[255]);
    step();
    chk("oor_fault", {31'b0, id_fault}, 32'd1);
    chk("oor_pc", id_pc, 32'h400);
    step();
    step();

    // Back-to-back redirects: first target must never appear
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_to(32'h20);
    step();
    chk("b2b_pc", id_pc, 32'h20);

    // Reset while stalled
    id_ready = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    chk("rst_stall_valid", {31'b0, id_valid}, 32'd0);
    chk("rst_stall_addr", imem_addr, 32'h0);
    chk("rst_stall_fault", {31'b0, id_fault}, 32'd0);
    rst_n = 1'b1;
    id_ready = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n          = ($urandom_range(0, 199) != 0);
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = rand_target();
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
